// File: rtl/fmul_share_if.sv
// Handshake and FMUL-side signal bundle for the shared multiplier controller.
interface fmul_share_if;
  logic        req0_valid;
  logic        req0_ready;
  logic [31:0] req0_a;
  logic [31:0] req0_b;
  logic        req1_valid;
  logic        req1_ready;
  logic [31:0] req1_a;
  logic [31:0] req1_b;
  logic        resp_valid;
  logic        resp_ready;
  logic        resp_id;
  logic [31:0] resp_data;
  logic [31:0] mul_a;
  logic [31:0] mul_b;
  logic [31:0] mul_result;

  // Controller side: takes requests, drives responses and the multiplier.
  modport slave (
    input  req0_valid, req0_a, req0_b,
    input  req1_valid, req1_a, req1_b,
    input  resp_ready, mul_result,
    output req0_ready, req1_ready,
    output resp_valid, resp_id, resp_data,
    output mul_a, mul_b
  );

  // Environment side: requesters, response consumer and the FMUL itself.
  modport master (
    output req0_valid, req0_a, req0_b,
    output req1_valid, req1_a, req1_b,
    output resp_ready, mul_result,
    input  req0_ready, req1_ready,
    input  resp_valid, resp_id, resp_data,
    input  mul_a, mul_b
  );
endinterface

// File: rtl/fmul_share_ctrl.sv
// Round-robin sharer of one combinational FMUL between two requesters,
// holding operands for LAT cycles so the multiplier can be a multicycle path.
module fmul_share_ctrl #(
  parameter int unsigned LAT = 1,
  parameter int unsigned CW  = $clog2(LAT + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  fmul_share_if.slave   bus,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_e;

  state_e        state_q, state_d;
  logic [31:0]   op_a_q, op_a_d;
  logic [31:0]   op_b_q, op_b_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          rid_q, rid_d;
  logic          rvalid_q, rvalid_d;
  logic          last_grant_q, last_grant_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic gnt_vld;
  logic gnt;

  // Tie goes to the requester that did not win last time.
  assign gnt_vld = bus.req0_valid | bus.req1_valid;
  assign gnt     = (bus.req0_valid & bus.req1_valid) ? ~last_grant_q : bus.req1_valid;

  assign bus.req0_ready = rst_n & (state_q == IDLE) & gnt_vld & ~gnt;
  assign bus.req1_ready = rst_n & (state_q == IDLE) & gnt_vld &  gnt;
  assign busy           = (state_q != IDLE);

  assign bus.mul_a      = op_a_q;
  assign bus.mul_b      = op_b_q;
  assign bus.resp_valid = rvalid_q;
  assign bus.resp_id    = rid_q;
  assign bus.resp_data  = rdata_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      op_a_q       <= '0;
      op_b_q       <= '0;
      rdata_q      <= '0;
      rid_q        <= 1'b0;
      rvalid_q     <= 1'b0;
      last_grant_q <= 1'b1;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      rdata_q      <= rdata_d;
      rid_q        <= rid_d;
      rvalid_q     <= rvalid_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    rdata_d      = rdata_q;
    rid_d        = rid_q;
    rvalid_d     = rvalid_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (gnt_vld) begin
          op_a_d       = gnt ? bus.req1_a : bus.req0_a;
          op_b_d       = gnt ? bus.req1_b : bus.req0_b;
          rid_d        = gnt;
          last_grant_d = gnt;
          cnt_d        = CW'(LAT - 1);
          state_d      = ISSUE;
        end
      end
      ISSUE: begin
        // Result is sampled at the end of the LAT-th hold cycle.
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          rdata_d  = bus.mul_result;
          rvalid_d = 1'b1;
          state_d  = RESP;
        end
      end
      RESP: begin
        if (bus.resp_ready) begin
          rvalid_d = 1'b0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_fmul_share_ctrl.sv
// Directed bench: cycle table on a LAT=1 instance, hand sequences on a LAT=4 instance.
module tb_fmul_share_ctrl;

  localparam logic [31:0] F1 = 32'h3F800000;
  localparam logic [31:0] F2 = 32'h40000000;
  localparam logic [31:0] F3 = 32'h40400000;
  localparam logic [31:0] F6 = 32'h40C00000;

  logic clk = 1'b0;
  logic rst1_n, rst4_n;
  logic busy1, busy4;
  int   errors = 0;
  int   checks = 0;
  int   stub_cnt = 0;

  fmul_share_if i1 ();
  fmul_share_if i4 ();

  fmul_share_ctrl #(.LAT(1)) dut1 (.clk(clk), .rst_n(rst1_n), .bus(i1), .busy(busy1));
  fmul_share_ctrl #(.LAT(4)) dut4 (.clk(clk), .rst_n(rst4_n), .bus(i4), .busy(busy4));

  initial forever #5 clk = ~clk;

  // Stand-in FMUL: known products for the operands used, quiet NaN otherwise.
  function automatic logic [31:0] fmul_model(input logic [31:0] a, input logic [31:0] b);
    if (a == F2 && b == F3) return F6;
    if (a == F1 && b == F1) return F1;
    return 32'h7FC00000;
  endfunction

  assign i1.mul_result = fmul_model(i1.mul_a, i1.mul_b);
  // Stub output changes shortly after every edge so the sampling cycle is visible.
  assign i4.mul_result = {16'hCAFE, 16'(stub_cnt)};
  initial forever begin
    @(posedge clk);
    #2 stub_cnt = stub_cnt + 1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        rst_n, v0, v1, rr;
    logic [31:0] a0, b0;
    logic        e_r0, e_r1, e_busy, e_rv, e_rid;
    logic [31:0] e_data;
  } vec_t;

  vec_t tbl [26];
  int   h;

  initial begin
    // rst, v0, v1, rr, a0, b0 | ready0, ready1, busy, resp_valid, resp_id, resp_data
    tbl[0]  = '{1, 1, 0, 1, F2, F3, 1, 0, 0, 0, 0, 0};   // single request
    tbl[1]  = '{1, 0, 0, 1, F2, F3, 0, 0, 1, 0, 0, 0};
    tbl[2]  = '{1, 0, 0, 1, F2, F3, 0, 0, 1, 1, 0, F6};
    tbl[3]  = '{0, 1, 1, 1, F1, F1, 0, 0, 0, 0, 0, 0};   // reset: ready forced low
    tbl[4]  = '{1, 1, 1, 1, F1, F1, 1, 0, 0, 0, 0, 0};   // tie, req0 first
    tbl[5]  = '{1, 1, 1, 1, F1, F1, 0, 0, 1, 0, 0, 0};
    tbl[6]  = '{1, 1, 1, 1, F1, F1, 0, 0, 1, 1, 0, F1};
    tbl[7]  = '{1, 1, 1, 1, F1, F1, 0, 1, 0, 0, 0, 0};
    tbl[8]  = '{1, 1, 1, 1, F1, F1, 0, 0, 1, 0, 0, 0};
    tbl[9]  = '{1, 1, 1, 1, F1, F1, 0, 0, 1, 1, 1, F6};
    tbl[10] = '{1, 1, 1, 1, F1, F1, 1, 0, 0, 0, 0, 0};
    tbl[11] = '{1, 1, 1, 1, F1, F1, 0, 0, 1, 0, 0, 0};
    tbl[12] = '{1, 1, 1, 0, F1, F1, 0, 0, 1, 1, 0, F1};  // backpressure
    tbl[13] = '{1, 1, 1, 0, F1, F1, 0, 0, 1, 1, 0, F1};
    tbl[14] = '{1, 1, 1, 0, F1, F1, 0, 0, 1, 1, 0, F1};
    tbl[15] = '{1, 1, 1, 0, F1, F1, 0, 0, 1, 1, 0, F1};
    tbl[16] = '{1, 1, 1, 0, F1, F1, 0, 0, 1, 1, 0, F1};
    tbl[17] = '{1, 1, 1, 1, F1, F1, 0, 0, 1, 1, 0, F1};
    tbl[18] = '{1, 1, 0, 1, F1, F1, 1, 0, 0, 0, 0, 0};
    tbl[19] = '{1, 0, 0, 1, F1, F1, 0, 0, 1, 0, 0, 0};
    tbl[20] = '{1, 0, 1, 0, F1, F1, 0, 0, 1, 1, 0, F1};  // req1 pulse during RESP
    tbl[21] = '{1, 0, 0, 1, F1, F1, 0, 0, 1, 1, 0, F1};
    tbl[22] = '{1, 1, 1, 1, F1, F1, 0, 1, 0, 0, 0, 0};   // last grant still 0
    tbl[23] = '{1, 0, 0, 1, F1, F1, 0, 0, 1, 0, 0, 0};
    tbl[24] = '{1, 0, 0, 1, F1, F1, 0, 0, 1, 1, 1, F6};
    tbl[25] = '{1, 0, 0, 1, F1, F1, 0, 0, 0, 0, 0, 0};

    rst1_n = 1'b0; rst4_n = 1'b0;
    i1.req0_valid = 1'b0; i1.req1_valid = 1'b0; i1.resp_ready = 1'b1;
    i1.req0_a = '0; i1.req0_b = '0; i1.req1_a = F2; i1.req1_b = F3;
    i4.req0_valid = 1'b0; i4.req1_valid = 1'b0; i4.resp_ready = 1'b1;
    i4.req0_a = '0; i4.req0_b = '0; i4.req1_a = '0; i4.req1_b = '0;
    repeat (2) @(posedge clk);
    #1;

    // LAT=1 cycle table
    for (int i = 0; i < 26; i++) begin
      rst1_n = tbl[i].rst_n;
      i1.req0_valid = tbl[i].v0;
      i1.req1_valid = tbl[i].v1;
      i1.resp_ready = tbl[i].rr;
      i1.req0_a = tbl[i].a0;
      i1.req0_b = tbl[i].b0;
      @(negedge clk);
      chk($sformatf("row%0d req0_ready", i), 32'(i1.req0_ready), 32'(tbl[i].e_r0));
      chk($sformatf("row%0d req1_ready", i), 32'(i1.req1_ready), 32'(tbl[i].e_r1));
      chk($sformatf("row%0d busy", i), 32'(busy1), 32'(tbl[i].e_busy));
      chk($sformatf("row%0d resp_valid", i), 32'(i1.resp_valid), 32'(tbl[i].e_rv));
      if (tbl[i].e_rv) begin
        chk($sformatf("row%0d resp_id", i), 32'(i1.resp_id), 32'(tbl[i].e_rid));
        chk($sformatf("row%0d resp_data", i), i1.resp_data, tbl[i].e_data);
      end
      @(posedge clk);
      #1;
    end

    // LAT=4: operands held four cycles, result taken on the last hold cycle
    rst4_n = 1'b1;
    i4.req0_valid = 1'b1; i4.req0_a = 32'h11111111; i4.req0_b = 32'h22222222;
    @(negedge clk);
    chk("lat4 req0_ready", 32'(i4.req0_ready), 32'd1);
    chk("lat4 idle busy", 32'(busy4), 32'd0);
    h = stub_cnt;
    @(posedge clk); #1;
    i4.req0_valid = 1'b0; i4.req0_a = 32'hDEADDEAD; i4.req0_b = 32'hBEEFBEEF;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk($sformatf("lat4 hold%0d busy", k), 32'(busy4), 32'd1);
      chk($sformatf("lat4 hold%0d mul_a", k), i4.mul_a, 32'h11111111);
      chk($sformatf("lat4 hold%0d mul_b", k), i4.mul_b, 32'h22222222);
      chk($sformatf("lat4 hold%0d resp_valid", k), 32'(i4.resp_valid), 32'd0);
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("lat4 resp_valid", 32'(i4.resp_valid), 32'd1);
    chk("lat4 resp_id", 32'(i4.resp_id), 32'd0);
    chk("lat4 resp_data", i4.resp_data, {16'hCAFE, 16'(h + 4)});
    @(posedge clk); #1;
    @(negedge clk);
    chk("lat4 done resp_valid", 32'(i4.resp_valid), 32'd0);
    chk("lat4 done busy", 32'(busy4), 32'd0);

    // Reset during ISSUE aborts the op and restores req0 priority on a tie
    @(posedge clk); #1;
    i4.req0_valid = 1'b1; i4.req0_a = 32'h33333333; i4.req0_b = 32'h44444444;
    @(negedge clk);
    chk("abort req0_ready", 32'(i4.req0_ready), 32'd1);
    @(posedge clk); #1;
    i4.req0_valid = 1'b0;
    @(posedge clk); #1;
    rst4_n = 1'b0;
    i4.req0_valid = 1'b1; i4.req1_valid = 1'b1;
    i4.req1_a = 32'h55555555; i4.req1_b = 32'h66666666;
    @(negedge clk);
    chk("rst req0_ready", 32'(i4.req0_ready), 32'd0);
    chk("rst req1_ready", 32'(i4.req1_ready), 32'd0);
    @(posedge clk); #1;
    rst4_n = 1'b1;
    @(negedge clk);
    chk("post-rst busy", 32'(busy4), 32'd0);
    chk("post-rst resp_valid", 32'(i4.resp_valid), 32'd0);
    chk("post-rst resp_data", i4.resp_data, 32'd0);
    chk("post-rst resp_id", 32'(i4.resp_id), 32'd0);
    chk("post-rst tie req0_ready", 32'(i4.req0_ready), 32'd1);
    chk("post-rst tie req1_ready", 32'(i4.req1_ready), 32'd0);
    #1 i4.req0_valid = 1'b0;
    #1 chk("post-rst req1_ready", 32'(i4.req1_ready), 32'd1);
    h = stub_cnt;
    @(posedge clk); #1;
    i4.req1_valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk($sformatf("req1 hold%0d resp_valid", k), 32'(i4.resp_valid), 32'd0);
      chk($sformatf("req1 hold%0d mul_a", k), i4.mul_a, 32'h55555555);
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("req1 resp_valid", 32'(i4.resp_valid), 32'd1);
    chk("req1 resp_id", 32'(i4.resp_id), 32'd1);
    chk("req1 resp_data", i4.resp_data, {16'hCAFE, 16'(h + 4)});
    @(posedge clk); #1;
    @(negedge clk);
    chk("req1 done resp_valid", 32'(i4.resp_valid), 32'd0);
    chk("req1 done busy", 32'(busy4), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
